// File: rtl/scan_fifo_sync.sv
// rtl/scan_fifo_sync.sv - single-clock FWFT FIFO between the scan DMA read and write paths
// Registered occupancy drives all status flags; only rd_en feeds push acceptance when full.
module scan_fifo_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic rd_pop;
  logic wr_push;
  logic mem_we;
  logic ovf_set;
  logic udf_set;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign dout        = mem_q[rd_ptr_q];

  // A pop while full frees the slot the simultaneous push lands in.
  assign rd_pop  = rd_en & ~empty;
  assign wr_push = wr_en & (~full | rd_en);
  assign mem_we  = wr_push & ~flush & ~ARESET;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_set     = 1'b0;
    udf_set     = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      ovf_set = wr_en & ~wr_push;
      udf_set = rd_en & empty;
      if (wr_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_push, rd_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // Set beats clear when both happen in the same cycle.
    overflow_d  = (overflow_q  & ~err_clr) | ovf_set;
    underflow_d = (underflow_q & ~err_clr) | udf_set;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) mem_q[wr_ptr_q] <= din;
  end

endmodule
